// File: rtl/dmem_arbiter.sv
// Round-robin arbiter giving two masters alternating single-cycle access to a
// single-port data RAM, with registered read return per port.
module dmem_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  clear,
   input  logic                  m0_req,
   input  logic                  m0_we,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   output logic                  m0_gnt,
   output logic                  m0_rvalid,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   input  logic                  m1_req,
   input  logic                  m1_we,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   output logic                  m1_gnt,
   output logic                  m1_rvalid,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_wren,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   state_t                  state_r;
   state_t                  state_nxt_s;
   logic                    owner_r;
   logic                    owner_nxt_s;
   logic                    last_owner_r;
   logic [ADDR_WIDTH-1:0]   hold_addr_r;
   logic [DATA_WIDTH-1:0]   hold_wdata_r;
   logic                    own_we_s;
   logic [ADDR_WIDTH-1:0]   own_addr_s;
   logic [DATA_WIDTH-1:0]   own_wdata_s;

   // The owner's inputs are used live so the access reflects whatever it presents now.
   assign own_we_s    = owner_r ? m1_we    : m0_we;
   assign own_addr_s  = owner_r ? m1_addr  : m0_addr;
   assign own_wdata_s = owner_r ? m1_wdata : m0_wdata;

   // State register: FSM state, arbitration history and grant pulses.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state_r      <= IDLE;
         owner_r      <= 1'b0;
         last_owner_r <= 1'b1;
         m0_gnt       <= 1'b0;
         m1_gnt       <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         owner_r <= owner_nxt_s;
         m0_gnt  <= (state_nxt_s == ACCESS) && (owner_nxt_s == 1'b0);
         m1_gnt  <= (state_nxt_s == ACCESS) && (owner_nxt_s == 1'b1);
         if (state_r == ACCESS) begin
            last_owner_r <= owner_r;
         end
      end
   end

   // Next-state: pick a winner from IDLE, ACCESS always lasts one cycle.
   always_comb begin
      state_nxt_s = state_r;
      owner_nxt_s = owner_r;
      case (state_r)
         IDLE: begin
            if (m0_req && m1_req) begin
               state_nxt_s = ACCESS;
               owner_nxt_s = ~last_owner_r;
            end else if (m0_req) begin
               state_nxt_s = ACCESS;
               owner_nxt_s = 1'b0;
            end else if (m1_req) begin
               state_nxt_s = ACCESS;
               owner_nxt_s = 1'b1;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ACCESS: begin
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
            owner_nxt_s = 1'b0;
         end
      endcase
   end

   // Memory drive: owner's request during ACCESS, otherwise hold; clear kills a pending write.
   always_comb begin
      mem_addr  = hold_addr_r;
      mem_wdata = hold_wdata_r;
      mem_wren  = 1'b0;
      if (state_r == ACCESS) begin
         mem_addr  = own_addr_s;
         mem_wdata = own_wdata_s;
         mem_wren  = own_we_s & ~clear;
      end else begin
         mem_addr  = hold_addr_r;
         mem_wdata = hold_wdata_r;
         mem_wren  = 1'b0;
      end
   end

   // Datapath registers: read return, rvalid pulses and held memory drive.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         m0_rdata     <= {DATA_WIDTH{1'b0}};
         m1_rdata     <= {DATA_WIDTH{1'b0}};
         m0_rvalid    <= 1'b0;
         m1_rvalid    <= 1'b0;
         hold_addr_r  <= {ADDR_WIDTH{1'b0}};
         hold_wdata_r <= {DATA_WIDTH{1'b0}};
      end else begin
         m0_rvalid <= 1'b0;
         m1_rvalid <= 1'b0;
         if (state_r == ACCESS) begin
            hold_addr_r  <= own_addr_s;
            hold_wdata_r <= own_wdata_s;
            if (!own_we_s) begin
               if (owner_r == 1'b0) begin
                  m0_rdata  <= mem_rdata;
                  m0_rvalid <= 1'b1;
               end else begin
                  m1_rdata  <= mem_rdata;
                  m1_rvalid <= 1'b1;
               end
            end
         end
      end
   end

endmodule
